led_mode_sequencer: RTL and testbench

Controller that sequences the 8-LED display through four pattern modes using a clock prescaler.
- Modes: fill/drain, walking one, blink, centre-out.
- Sits between the board clock/reset and the LED output pins; replaces the single fixed-pattern LED blocks.
- Mode is selected externally or advanced automatically at the end of each pattern period.

---
 rtl/led_seq_pkg.sv | 55 +++++
 rtl/led_tick_gen.sv | 45 ++++
 rtl/led_mode_sequencer.sv | 96 +++++++++
 tb/tb_led_mode_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : led_seq_pkg
// Description : Mode codes plus the per-mode step limit and LED pattern
//               functions shared by the LED mode sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package led_seq_pkg;

  // Widest LED bank the pattern function can describe.
  localparam int MAX_WIDTH = 64;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_FILL_DRAIN = 2'd0;
  localparam mode_t MODE_SHIFT      = 2'd1;
  localparam mode_t MODE_BLINK      = 2'd2;
  localparam mode_t MODE_CENTRE     = 2'd3;

  // Index of the final step of a mode's period.
  function automatic int last_step(input mode_t mode, input int width);
    int r;
    case (mode)
      MODE_FILL_DRAIN: r = 2 * width - 1;
      MODE_SHIFT:      r = width - 1;
      MODE_BLINK:      r = 1;
      default:         r = width / 2;
    endcase
    return r;
  endfunction

  // LED image for a given mode and step; bits at or above width stay zero.
  function automatic logic [MAX_WIDTH-1:0] pattern(input mode_t mode, input int step,
                                                   input int width);
    logic [MAX_WIDTH-1:0] p;
    p = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < width) begin
        case (mode)
          // Fill from the bottom, then drain from the bottom.
          MODE_FILL_DRAIN: p[i] = (step <= width) ? (i < step) : (i >= step - width);
          MODE_SHIFT:      p[i] = (i == step);
          MODE_BLINK:      p[i] = (step == 0);
          // Band of 2*step lit bits centred on the bank.
          default:         p[i] = (step != 0) && (i >= width / 2 - step) &&
                                  (i < width / 2 + step);
        endcase
      end
    end
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_tick_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : led_tick_gen
// Description : Pattern-step prescaler. Counts 0..DIV-1 on non-paused cycles
//               and raises step_tick while at the terminal count.
// Revision    : 1.0 - initial release
// ============================================================================
module led_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic pause,
  output logic step_tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             w_at_last;

  // Next count and the tick strobe; pause holds the count and masks the tick.
  always_comb begin
    w_at_last = (cnt_q == CNT_LAST);
    step_tick = w_at_last & ~pause;
    cnt_d     = cnt_q;
    if (!pause) begin
      cnt_d = w_at_last ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Prescaler count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/led_mode_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : led_mode_sequencer
// Description : Steps an LED bank through fill/drain, walking-one, blink and
//               centre-out patterns. The mode is chosen at each period wrap,
//               either from mode_sel or by auto-advance.
//               Build option LED_ACTIVE_LOW_EN: drive out inverted (reset
//               value all ones).
// Revision    : 1.0 - initial release
// ============================================================================
module led_mode_sequencer
  import led_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode_sel,
  input  logic             auto_en,
  input  logic             pause,
  output logic [WIDTH-1:0] out,
  output logic [1:0]       mode_cur,
  output logic             step_tick,
  output logic             done
);

  // Fill/drain has the longest period: steps 0..2*WIDTH-1.
  localparam int STEP_W = $clog2(2 * WIDTH);

`ifdef LED_ACTIVE_LOW_EN
  localparam logic [WIDTH-1:0] OUT_RST = '1;
`else
  localparam logic [WIDTH-1:0] OUT_RST = '0;
`endif

  mode_t             mode_q, mode_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  w_pat;

  led_tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk       (clk),
    .reset     (reset),
    .pause     (pause),
    .step_tick (step_tick)
  );

  // Step/mode advance on each tick, choosing the next mode at the wrap, and
  // the LED image for the state being entered so out tracks step and mode.
  always_comb begin
    mode_d = mode_q;
    step_d = step_q;
    done_d = 1'b0;
    if (step_tick) begin
      if (int'(step_q) < last_step(mode_q, WIDTH)) begin
        step_d = step_q + STEP_W'(1);
      end else begin
        step_d = '0;
        done_d = 1'b1;
        mode_d = auto_en ? mode_q + 2'd1 : mode_sel;
      end
    end
    w_pat = WIDTH'(pattern(mode_d, int'(step_d), WIDTH));
`ifdef LED_ACTIVE_LOW_EN
    out_d = ~w_pat;
`else
    out_d = w_pat;
`endif
  end

  // Sequencer state and registered LED drive.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q <= MODE_FILL_DRAIN;
      step_q <= '0;
      out_q  <= OUT_RST;
      done_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      step_q <= step_d;
      out_q  <= out_d;
      done_q <= done_d;
    end
  end

  assign out      = out_q;
  assign mode_cur = mode_q;
  assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_led_mode_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_led_mode_sequencer
// Description : Self-checking bench for led_mode_sequencer (WIDTH=8, DIV=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_mode_sequencer;

  localparam int W = 8;
  localparam int D = 2;

  logic       clk      = 1'b0;
  logic       reset    = 1'b0;
  logic [1:0] mode_sel = 2'd0;
  logic       auto_en  = 1'b0;
  logic       pause    = 1'b0;
  logic [7:0] out;
  logic [1:0] mode_cur;
  logic       step_tick;
  logic       done;

  led_mode_sequencer #(
    .WIDTH (W),
    .DIV   (D)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mode_sel  (mode_sel),
    .auto_en   (auto_en),
    .pause     (pause),
    .out       (out),
    .mode_cur  (mode_cur),
    .step_tick (step_tick),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: current mode, step index into that mode's sequence,
  // count of non-paused cycles modulo DIV, and the expected done pulse.
  int   m_mode, m_k, m_pre;
  logic m_done;
  int   seq_len [4] = '{2 * W, W, 2, W / 2 + 1};

  typedef struct {
    logic       pause;
    logic       auto_en;
    logic [1:0] sel;
    logic [7:0] exp_out;
    logic       exp_done;
  } vec_t;
  vec_t vt[$];

  logic [7:0] fd_seq [16] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
                              8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};

  function automatic logic [7:0] ref_pat(input int m, input int k);
    logic [7:0] r;
    case (m)
      0:       r = (k <= W) ? 8'((1 << k) - 1) : 8'(8'hFF << (k - W));
      1:       r = 8'(1 << k);
      2:       r = (k == 0) ? 8'hFF : 8'h00;
      default: r = (k == 0) ? 8'h00 : 8'(((1 << (2 * k)) - 1) << (W / 2 - k));
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_k    = 0;
    m_pre  = 0;
    m_done = 1'b0;
  endtask

  // One clock: check the tick for the current inputs, advance the model,
  // take the edge, then check the registered outputs.
  task automatic cycle();
    #1;
    chk("step_tick", step_tick, (m_pre == D - 1) && !pause);
    m_done = 1'b0;
    if (!pause) begin
      if (m_pre == D - 1) begin
        if (m_k == seq_len[m_mode] - 1) begin
          m_k    = 0;
          m_done = 1'b1;
          m_mode = auto_en ? (m_mode + 1) % 4 : int'(mode_sel);
        end else begin
          m_k++;
        end
      end
      m_pre = (m_pre + 1) % D;
    end
    @(posedge clk);
    #1;
    chk("out", out, ref_pat(m_mode, m_k));
    chk("mode_cur", mode_cur, m_mode);
    chk("done", done, m_done);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Asynchronous reset between edges; outputs must clear before any edge.
  task automatic async_reset();
    #2;
    reset = 1'b0;
    #1;
    chk("rst_out", out, 8'h00);
    chk("rst_mode", mode_cur, 2'd0);
    chk("rst_tick", step_tick, 1'b0);
    chk("rst_done", done, 1'b0);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    // Reset asserted from time zero, checked before any clock edge.
    #2;
    chk("init_out", out, 8'h00);
    chk("init_mode", mode_cur, 2'd0);
    chk("init_tick", step_tick, 1'b0);
    chk("init_done", done, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("post_rst_out", out, 8'h00);

    // Table: one mode-0 period, each step held DIV=2 cycles, wrap with done.
    for (int j = 1; j <= 32; j++) begin
      vec_t v;
      v.pause    = 1'b0;
      v.auto_en  = 1'b0;
      v.sel      = 2'd0;
      v.exp_out  = fd_seq[(j / 2) % 16];
      v.exp_done = (j == 32);
      vt.push_back(v);
    end
    for (int i = 0; i < vt.size(); i++) begin
      pause    = vt[i].pause;
      auto_en  = vt[i].auto_en;
      mode_sel = vt[i].sel;
      cycle();
      chk("tbl_out", out, vt[i].exp_out);
      chk("tbl_done", done, vt[i].exp_done);
    end

    // Auto cycling through all four modes and back to fill/drain.
    auto_en = 1'b1;
    run(32);
    chk("auto_m1", mode_cur, 2'd1);
    chk("auto_m1_out", out, 8'h01);
    run(16);
    chk("auto_m2", mode_cur, 2'd2);
    chk("auto_m2_out", out, 8'hFF);
    run(4);
    chk("auto_m3", mode_cur, 2'd3);
    chk("auto_m3_out", out, 8'h00);
    run(10);
    chk("auto_m0", mode_cur, 2'd0);
    chk("auto_m0_done", done, 1'b1);

    // Mid-period select change is deferred to the wrap.
    auto_en = 1'b0;
    run(10);
    chk("mid_1F", out, 8'h1F);
    mode_sel = 2'd2;
    run(20);
    chk("mid_80", out, 8'h80);
    chk("mid_still0", mode_cur, 2'd0);
    run(2);
    chk("mid_m2", mode_cur, 2'd2);
    chk("mid_FF", out, 8'hFF);

    // Pause with the prescaler mid-count while showing 07.
    mode_sel = 2'd0;
    run(4);
    run(7);
    chk("pz_07", out, 8'h07);
    pause = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("pz_hold", out, 8'h07);
      chk("pz_tick", step_tick, 1'b0);
    end
    pause = 1'b0;
    run(1);
    chk("pz_0F", out, 8'h0F);

    // Run into mode 3, then reset asynchronously while it shows 3C.
    mode_sel = 2'd3;
    run(25);
    run(4);
    chk("m3_3C", out, 8'h3C);
    chk("m3_mode", mode_cur, 2'd3);
    async_reset();
    mode_sel = 2'd0;
    run(3);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      pause    = ($urandom_range(0, 7) == 0);
      mode_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) auto_en = ~auto_en;
      if ($urandom_range(0, 199) == 0) async_reset();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
